// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller: FSM states, ALU controls,
// datapath select codes, condition codes and NZCV bit positions.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOrr = 3'b011
    } alu_ctl_t;

    localparam logic [1:0] SrcARd1   = 2'd0;
    localparam logic [1:0] SrcAPc    = 2'd1;
    localparam logic [1:0] SrcBRd2   = 2'd0;
    localparam logic [1:0] SrcBImm   = 2'd1;
    localparam logic [1:0] SrcBFour  = 2'd2;
    localparam logic [1:0] ResAluOut = 2'd0;
    localparam logic [1:0] ResData   = 2'd1;
    localparam logic [1:0] ResAlu    = 2'd2;

    localparam logic [1:0] OpDp  = 2'b00;
    localparam logic [1:0] OpMem = 2'b01;
    localparam logic [1:0] OpBr  = 2'b10;

    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdOrr = 4'b1100;
    localparam logic [3:0] CmdCmp = 4'b1010;

    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against a stored NZCV nibble.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;

    always_comb begin
        n = flags_i[FlagN];
        z = flags_i[FlagZ];
        c = flags_i[FlagC];
        v = flags_i[FlagV];
        cond_ex_o = 1'b1;
        unique case (cond_i)
            CondEq:  cond_ex_o = z;
            CondNe:  cond_ex_o = ~z;
            CondCs:  cond_ex_o = c;
            CondCc:  cond_ex_o = ~c;
            CondMi:  cond_ex_o = n;
            CondPl:  cond_ex_o = ~n;
            CondVs:  cond_ex_o = v;
            CondVc:  cond_ex_o = ~v;
            CondHi:  cond_ex_o = c & ~z;
            CondLs:  cond_ex_o = ~c | z;
            CondGe:  cond_ex_o = (n == v);
            CondLt:  cond_ex_o = (n != v);
            CondGt:  cond_ex_o = ~z & (n == v);
            CondLe:  cond_ex_o = z | (n != v);
            default: cond_ex_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM sequencing controller: one FSM state per cycle, predicated writes via the
// stored NZCV flags, and memory-ready stalls on FETCH, MEMREAD and MEMWRITE.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter bit         USE_MEM_READY = 1'b1,
    parameter logic [3:0] FLAGS_RESET   = 4'b0000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [3:0] rd_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [1:0] imm_src_o,
    output logic [1:0] reg_src_o,
    output logic [2:0] alu_ctl_o,
    output logic       carry_o,
    output logic [3:0] dbg_state_o
);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic       ready;
    logic       wb_pc;
    alu_ctl_t   cmd_ctl;
    logic       no_write;
    logic       cv_upd;

    cond_check u_cond_check (
        .cond_i    (cond_i),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    assign ready = USE_MEM_READY ? mem_ready_i : 1'b1;
    assign wb_pc = (rd_i == 4'd15);

    always_comb begin
        cmd_ctl  = AluAdd;
        no_write = 1'b1;
        cv_upd   = 1'b0;
        unique case (funct_i[4:1])
            CmdAdd:  begin cmd_ctl = AluAdd; no_write = 1'b0; cv_upd = 1'b1; end
            CmdSub:  begin cmd_ctl = AluSub; no_write = 1'b0; cv_upd = 1'b1; end
            CmdAnd:  begin cmd_ctl = AluAnd; no_write = 1'b0; end
            CmdOrr:  begin cmd_ctl = AluOrr; no_write = 1'b0; end
            CmdCmp:  begin cmd_ctl = AluSub; cv_upd = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = SrcARd1;
        alu_src_b_o  = SrcBRd2;
        result_src_o = ResAluOut;
        alu_ctl_o    = AluAdd;
        unique case (state_q)
            StFetch: begin
                alu_src_a_o  = SrcAPc;
                alu_src_b_o  = SrcBFour;
                result_src_o = ResAlu;
                if (ready) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                alu_src_a_o  = SrcAPc;
                alu_src_b_o  = SrcBFour;
                result_src_o = ResAlu;
                unique case (op_i)
                    OpMem:   state_d = StMemAdr;
                    OpDp:    state_d = funct_i[5] ? StExecI : StExecR;
                    OpBr:    state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                alu_src_b_o = SrcBImm;
                state_d     = funct_i[0] ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src_o = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src_o = ResData;
                pc_write_o   = cond_ex & wb_pc;
                reg_write_o  = cond_ex & ~wb_pc;
                state_d      = StFetch;
            end
            StMemWrite: begin
                adr_src_o   = 1'b1;
                mem_write_o = cond_ex & ready;
                if (ready) state_d = StFetch;
            end
            StExecR: begin
                alu_ctl_o = cmd_ctl;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_b_o = SrcBImm;
                alu_ctl_o   = cmd_ctl;
                state_d     = StAluWb;
            end
            StAluWb: begin
                pc_write_o  = cond_ex & ~no_write & wb_pc;
                reg_write_o = cond_ex & ~no_write & ~wb_pc;
                state_d     = StFetch;
            end
            StBranch: begin
                alu_src_b_o  = SrcBImm;
                result_src_o = ResAlu;
                pc_write_o   = cond_ex;
                state_d      = StFetch;
            end
            default: state_d = StFetch;
        endcase
        // Strobes must stay quiet in any cycle where reset is asserted.
        if (reset_i) begin
            pc_write_o  = 1'b0;
            ir_write_o  = 1'b0;
            mem_write_o = 1'b0;
            reg_write_o = 1'b0;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if ((state_q == StExecR || state_q == StExecI) && funct_i[0] && cond_ex) begin
            flags_d[FlagN] = alu_flags_i[FlagN];
            flags_d[FlagZ] = alu_flags_i[FlagZ];
            if (cv_upd) begin
                flags_d[FlagC] = alu_flags_i[FlagC];
                flags_d[FlagV] = alu_flags_i[FlagV];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StFetch;
            flags_q <= FLAGS_RESET;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    assign imm_src_o   = op_i;
    assign reg_src_o   = {(op_i == OpMem) & ~funct_i[0], op_i == OpBr};
    assign carry_o     = flags_q[FlagC];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a per-instruction phase model pushes expected outputs each cycle and a
// negedge monitor pops and compares them against the controller.
module tb_multicycle_controller;
    import arm_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, cond, alu_flags;
    logic       mem_ready;
    logic       pc_write, adr_src, ir_write, mem_write, reg_write, carry;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
    logic [2:0] alu_ctl;
    logic [3:0] dbg_state;

    logic [22:0] exp_q[$];
    logic [22:0] mask_q[$];
    logic [3:0]  nzcv;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [22:0] AllMask    = '1;
    localparam logic [22:0] StrobeMask = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 18'b0};

    always #5 clk = ~clk;

    multicycle_controller #(
        .USE_MEM_READY (1'b1),
        .FLAGS_RESET   (4'b0000)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .op_i         (op),
        .funct_i      (funct),
        .rd_i         (rd),
        .cond_i       (cond),
        .alu_flags_i  (alu_flags),
        .mem_ready_i  (mem_ready),
        .pc_write_o   (pc_write),
        .adr_src_o    (adr_src),
        .ir_write_o   (ir_write),
        .mem_write_o  (mem_write),
        .reg_write_o  (reg_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .result_src_o (result_src),
        .imm_src_o    (imm_src),
        .reg_src_o    (reg_src),
        .alu_ctl_o    (alu_ctl),
        .carry_o      (carry),
        .dbg_state_o  (dbg_state)
    );

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && n == v;
            4'd13: return z || n != v;
            default: return 1'b1;
        endcase
    endfunction

    // Returns {alu_ctl, no_write, updates_cv} for a cmd field.
    function automatic logic [4:0] cmd_info(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return {3'd0, 1'b0, 1'b1};
            4'b0010: return {3'd1, 1'b0, 1'b1};
            4'b0000: return {3'd2, 1'b0, 1'b0};
            4'b1100: return {3'd3, 1'b0, 1'b0};
            4'b1010: return {3'd1, 1'b1, 1'b1};
            default: return {3'd0, 1'b1, 1'b0};
        endcase
    endfunction

    function automatic logic [22:0] expect_vec(input state_t ph, input logic [1:0] o,
                                               input logic [5:0] f, input logic [3:0] r,
                                               input logic [3:0] c, input logic [3:0] fl,
                                               input bit rdy);
        bit pcw = 0, adr = 0, irw = 0, mw = 0, rw = 0;
        logic [1:0] a = 0, b = 0, res = 0;
        logic [2:0] alu = 0;
        logic [4:0] ci = cmd_info(f[4:1]);
        bit cx = cond_ok(c, fl);
        bit wr = cx && !ci[1];
        case (ph)
            StFetch:    begin a = 1; b = 2; res = 2; pcw = rdy; irw = rdy; end
            StDecode:   begin a = 1; b = 2; res = 2; end
            StMemAdr:   b = 1;
            StMemRead:  adr = 1;
            StMemWb:    begin res = 1; pcw = cx && r == 15; rw = cx && r != 15; end
            StMemWrite: begin adr = 1; mw = cx && rdy; end
            StExecR:    alu = ci[4:2];
            StExecI:    begin b = 1; alu = ci[4:2]; end
            StAluWb:    begin pcw = wr && r == 15; rw = wr && r != 15; end
            StBranch:   begin b = 1; res = 2; pcw = cx; end
            default:    ;
        endcase
        return {pcw, adr, irw, mw, rw, a, b, res, o, {o == 2'b01 && !f[0], o == 2'b10},
                alu, fl[1], 4'(ph)};
    endfunction

    function automatic state_t next_phase(input state_t ph, input logic [1:0] o,
                                          input logic [5:0] f, input bit rdy);
        case (ph)
            StFetch:    return rdy ? StDecode : StFetch;
            StDecode:   return o == 2'b01 ? StMemAdr : o == 2'b10 ? StBranch :
                               o == 2'b11 ? StFetch : (f[5] ? StExecI : StExecR);
            StMemAdr:   return f[0] ? StMemRead : StMemWrite;
            StMemRead:  return rdy ? StMemWb : StMemRead;
            StMemWrite: return rdy ? StFetch : StMemWrite;
            StExecR, StExecI: return StAluWb;
            default:    return StFetch;
        endcase
    endfunction

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            exp_q.push_back('0);
            mask_q.push_back(StrobeMask);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        nzcv  = 4'b0000;
    endtask

    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                             input logic [3:0] c, input logic [3:0] af, input int wr_stall,
                             input bit do_abort, input state_t abort_at);
        state_t ph = StFetch;
        bit left = 0;
        int guard = 0;
        int stall = wr_stall;
        bit rdy;
        logic [4:0] ci;
        while (!(left && ph == StFetch)) begin
            if (guard++ > 40) begin
                $display("FAIL instr_bound: still in phase %0d after %0d cycles, need FETCH",
                         ph, guard);
                n_err++;
                return;
            end
            if (do_abort && ph == abort_at) begin
                do_reset(3);
                return;
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (ph == StMemWrite && stall > 0) begin
                rdy = 1'b0;
                stall--;
            end
            op = o; funct = f; rd = r; cond = c; alu_flags = af; mem_ready = rdy;
            exp_q.push_back(expect_vec(ph, o, f, r, c, nzcv, rdy));
            mask_q.push_back(AllMask);
            ci = cmd_info(f[4:1]);
            if ((ph == StExecR || ph == StExecI) && f[0] && cond_ok(c, nzcv)) begin
                nzcv[3:2] = af[3:2];
                if (ci[0]) nzcv[1:0] = af[1:0];
            end
            if (next_phase(ph, o, f, rdy) != StFetch) left = 1;
            ph = next_phase(ph, o, f, rdy);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        logic [22:0] act, e, m;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m = mask_q.pop_front();
                act = {pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a, alu_src_b,
                       result_src, imm_src, reg_src, alu_ctl, carry, dbg_state};
                n_vec++;
                if ((act & m) !== (e & m)) begin
                    n_err++;
                    $display("FAIL cycle_outputs @%0t: got %h, expected %h (mask %h)",
                             $time, act, e, m);
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0] cmds[6];
        logic [3:0] cmd;
        reset = 1'b1; op = '0; funct = '0; rd = '0; cond = '0; alu_flags = '0;
        mem_ready = 1'b0; nzcv = '0;
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b0111;
        @(posedge clk);
        #1;
        do_reset(2);
        // Reset arriving mid-EXECR, then ADDS / EQ / STR stall / BEQ taken and not taken.
        run_instr(2'b00, 6'b001001, 4'd1, 4'hE, 4'b1111, 0, 1'b1, StExecR);
        run_instr(2'b00, 6'b101001, 4'd1, 4'hE, 4'b0110, 0, 1'b0, StFetch);
        run_instr(2'b00, 6'b001000, 4'd2, 4'h0, 4'b0000, 0, 1'b0, StFetch);
        run_instr(2'b01, 6'b011000, 4'd3, 4'hE, 4'b0000, 3, 1'b0, StFetch);
        run_instr(2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, 0, 1'b0, StFetch);
        run_instr(2'b00, 6'b000101, 4'd4, 4'hE, 4'b0000, 0, 1'b0, StFetch);
        run_instr(2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, 0, 1'b0, StFetch);
        // LDR to R15, CMP then ORRS.
        run_instr(2'b01, 6'b011001, 4'd15, 4'hE, 4'b0000, 0, 1'b0, StFetch);
        run_instr(2'b00, 6'b010101, 4'd5, 4'hE, 4'b0011, 0, 1'b0, StFetch);
        run_instr(2'b00, 6'b011001, 4'd6, 4'hE, 4'b1100, 0, 1'b0, StFetch);
        for (int i = 0; i < 60; i++) begin
            cmd = cmds[$urandom_range(0, 5)];
            run_instr(2'($urandom_range(0, 3)),
                      {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))},
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                      ($urandom_range(0, 19) == 0), StExecR);
        end
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
